// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//
// Sequences CSR instructions (CSRRW / CSRRS / CSRRC) and trap entry against
// a single-port CSR file. An instruction is a read cycle followed by an
// optional write cycle. Trap entry writes mepc (0x341) and mcause (0x342),
// then reads mtvec (0x305).
//
// Handshakes:
//   ins_req_i / ins_ack_o : the requester holds ins_req_i and its operands
//     until it sees ins_ack_o high. ins_ack_o is high only in the cycle
//     where the request is really taken at the next enabled edge.
//     Completion is signalled later by a one-cycle ins_done_o.
//   trap_req_i / trap_ack_o : the requester holds trap_req_i, trap_pc_i and
//     trap_cause_i until trap_ack_o, which marks the end of the whole trap
//     sequence. Traps win over instructions in IDLE. No request is taken
//     in the cycle where trap_ack_o is high, so a trap request that is
//     still held cannot start a second sequence.
//   With clk_en_i low nothing advances; pulses and strobes stay as they are
//   until the next enabled edge.
//
// Ports:
//   clk_i, resetb_i       clock, asynchronous active-low reset
//   clk_en_i              clock enable for all state
//   ins_*_i               instruction request, op, address, operand, flags
//   ins_ack_o             accept pulse (same cycle as the accepting edge)
//   ins_done_o            completion pulse, qualified by ins_illegal_o
//   ins_rd_data_o         old CSR value, held until next capture
//   trap_req_i/pc/cause   trap entry request and its data
//   trap_ack_o            trap sequence done, trap_vec_o valid
//   csr_*                 CSR file port (combinational read data)
//   fsm_state_o           debug view of the sequencer state
// ---------------------------------------------------------------------------
module csr_access_ctrl #(
  parameter int C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  // instruction side
  input  logic              ins_req_i,
  input  logic [1:0]        ins_op_i,
  input  logic [11:0]       ins_addr_i,
  input  logic [C_XLEN-1:0] ins_src_i,
  input  logic              ins_rd_nz_i,
  input  logic              ins_src_nz_i,
  output logic              ins_ack_o,
  output logic              ins_done_o,
  output logic              ins_illegal_o,
  output logic [C_XLEN-1:0] ins_rd_data_o,
  // trap side
  input  logic              trap_req_i,
  input  logic [C_XLEN-1:0] trap_pc_i,
  input  logic [C_XLEN-1:0] trap_cause_i,
  output logic              trap_ack_o,
  output logic [C_XLEN-1:0] trap_vec_o,
  // CSR file port
  output logic              csr_rd_en_o,
  output logic              csr_wr_en_o,
  output logic [11:0]       csr_addr_o,
  output logic [C_XLEN-1:0] csr_wr_data_o,
  input  logic [C_XLEN-1:0] csr_rd_data_i,
  // debug
  output logic [2:0]        fsm_state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INS_RD     = 3'd1,
    INS_WR     = 3'd2,
    TRAP_EPC   = 3'd3,
    TRAP_CAUSE = 3'd4,
    TRAP_VEC   = 3'd5
  } state_t;

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVEC  = 12'h305;

  state_t              state;

  // operands captured at instruction accept
  logic [1:0]          op_q;
  logic [11:0]         addr_q;
  logic [C_XLEN-1:0]   src_q;
  logic                wr_need_q;
  logic                illegal_q;

  // cause is written one cycle after accept, so it is kept here
  logic [C_XLEN-1:0]   trap_cause_q;

  // decode of the incoming request. op 00 behaves as RW, so only op[1]
  // distinguishes RW from the read-modify-write flavours.
  logic                wr_need_in;
  logic                rd_need_in;
  logic                illegal_in;
  logic                idle_free;
  logic                trap_take;
  logic                ins_take;
  logic [C_XLEN-1:0]   wr_data_nx;

  assign wr_need_in = ~ins_op_i[1] | ins_src_nz_i;
  assign rd_need_in = ins_op_i[1] | ins_rd_nz_i;
  // addr[11:10] == 11 is the read-only CSR space
  assign illegal_in = wr_need_in & (ins_addr_i[11:10] == 2'b11);

  // trap_ack_o high means the trap requester has not yet had a chance to
  // drop its request; taking anything now would restart the trap.
  assign idle_free  = (state == IDLE) & ~trap_ack_o;
  assign trap_take  = idle_free & trap_req_i;
  assign ins_take   = idle_free & ins_req_i & ~trap_req_i;

  // the acknowledge is only shown when the accepting edge is enabled, so a
  // requester never drops its request for an accept that did not happen
  assign ins_ack_o  = ins_take & clk_en_i & resetb_i;

  assign fsm_state_o = state;

  // new CSR value, built from the value being read in INS_RD
  always_comb begin
    wr_data_nx = src_q;
    case (op_q)
      2'b10:   wr_data_nx = csr_rd_data_i | src_q;
      2'b11:   wr_data_nx = csr_rd_data_i & ~src_q;
      default: wr_data_nx = src_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state         <= IDLE;
      op_q          <= 2'b00;
      addr_q        <= '0;
      src_q         <= '0;
      wr_need_q     <= 1'b0;
      illegal_q     <= 1'b0;
      trap_cause_q  <= '0;
      ins_done_o    <= 1'b0;
      ins_illegal_o <= 1'b0;
      ins_rd_data_o <= '0;
      trap_ack_o    <= 1'b0;
      trap_vec_o    <= '0;
      csr_rd_en_o   <= 1'b0;
      csr_wr_en_o   <= 1'b0;
      csr_addr_o    <= '0;
      csr_wr_data_o <= '0;
    end else if (clk_en_i) begin
      // completion pulses last one enabled cycle
      ins_done_o    <= 1'b0;
      ins_illegal_o <= 1'b0;
      trap_ack_o    <= 1'b0;

      case (state)
        IDLE: begin
          csr_rd_en_o   <= 1'b0;
          csr_wr_en_o   <= 1'b0;
          csr_addr_o    <= '0;
          csr_wr_data_o <= '0;
          if (trap_take) begin
            trap_cause_q  <= trap_cause_i;
            csr_wr_en_o   <= 1'b1;
            csr_addr_o    <= ADDR_MEPC;
            csr_wr_data_o <= trap_pc_i;
            state         <= TRAP_EPC;
          end else if (ins_take) begin
            op_q        <= ins_op_i;
            addr_q      <= ins_addr_i;
            src_q       <= ins_src_i;
            wr_need_q   <= wr_need_in;
            illegal_q   <= illegal_in;
            csr_rd_en_o <= rd_need_in;
            csr_addr_o  <= ins_addr_i;
            state       <= INS_RD;
          end
        end

        INS_RD: begin
          // captured even when no read strobe was issued, so rd data is
          // always the value the write (if any) was based on
          ins_rd_data_o <= csr_rd_data_i;
          csr_rd_en_o   <= 1'b0;
          if (wr_need_q && !illegal_q) begin
            csr_wr_en_o   <= 1'b1;
            csr_addr_o    <= addr_q;
            csr_wr_data_o <= wr_data_nx;
            state         <= INS_WR;
          end else begin
            csr_addr_o    <= '0;
            ins_done_o    <= 1'b1;
            ins_illegal_o <= illegal_q;
            state         <= IDLE;
          end
        end

        INS_WR: begin
          csr_wr_en_o   <= 1'b0;
          csr_addr_o    <= '0;
          csr_wr_data_o <= '0;
          ins_done_o    <= 1'b1;
          state         <= IDLE;
        end

        TRAP_EPC: begin
          csr_addr_o    <= ADDR_MCAUSE;
          csr_wr_data_o <= trap_cause_q;
          state         <= TRAP_CAUSE;
        end

        TRAP_CAUSE: begin
          csr_wr_en_o   <= 1'b0;
          csr_wr_data_o <= '0;
          csr_rd_en_o   <= 1'b1;
          csr_addr_o    <= ADDR_MTVEC;
          state         <= TRAP_VEC;
        end

        TRAP_VEC: begin
          trap_vec_o  <= csr_rd_data_i;
          csr_rd_en_o <= 1'b0;
          csr_addr_o  <= '0;
          trap_ack_o  <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          csr_rd_en_o <= 1'b0;
          csr_wr_en_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_access_ctrl
//
// Directed bench for csr_access_ctrl. Each test pushes the events it expects
// (accept, CSR reads and writes, completion pulses) into exp_q and then
// drives the request. A monitor samples the DUT on the falling edge of every
// enabled cycle, turns what it sees into events and compares them in order
// against exp_q. Completion events also carry the enabled-cycle distance
// from the matching accept.
// ---------------------------------------------------------------------------
module tb_csr_access_ctrl;

  localparam int XL = 32;
  localparam int W  = 52;  // {kind[3], flag, lat[4], addr[12], data[32]}

  localparam logic [2:0] EV_ACK  = 3'd1;
  localparam logic [2:0] EV_RD   = 3'd2;
  localparam logic [2:0] EV_WR   = 3'd3;
  localparam logic [2:0] EV_DONE = 3'd4;
  localparam logic [2:0] EV_TACK = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetb_i;
  logic clk_en_i;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          ins_req_i;
  logic [1:0]    ins_op_i;
  logic [11:0]   ins_addr_i;
  logic [XL-1:0] ins_src_i;
  logic          ins_rd_nz_i;
  logic          ins_src_nz_i;
  logic          ins_ack_o;
  logic          ins_done_o;
  logic          ins_illegal_o;
  logic [XL-1:0] ins_rd_data_o;
  logic          trap_req_i;
  logic [XL-1:0] trap_pc_i;
  logic [XL-1:0] trap_cause_i;
  logic          trap_ack_o;
  logic [XL-1:0] trap_vec_o;
  logic          csr_rd_en_o;
  logic          csr_wr_en_o;
  logic [11:0]   csr_addr_o;
  logic [XL-1:0] csr_wr_data_o;
  logic [XL-1:0] csr_rd_data_i;
  logic [2:0]    fsm_state_o;

  csr_access_ctrl #(.C_XLEN(XL)) dut (
    .clk_i         (clk),
    .resetb_i      (resetb_i),
    .clk_en_i      (clk_en_i),
    .ins_req_i     (ins_req_i),
    .ins_op_i      (ins_op_i),
    .ins_addr_i    (ins_addr_i),
    .ins_src_i     (ins_src_i),
    .ins_rd_nz_i   (ins_rd_nz_i),
    .ins_src_nz_i  (ins_src_nz_i),
    .ins_ack_o     (ins_ack_o),
    .ins_done_o    (ins_done_o),
    .ins_illegal_o (ins_illegal_o),
    .ins_rd_data_o (ins_rd_data_o),
    .trap_req_i    (trap_req_i),
    .trap_pc_i     (trap_pc_i),
    .trap_cause_i  (trap_cause_i),
    .trap_ack_o    (trap_ack_o),
    .trap_vec_o    (trap_vec_o),
    .csr_rd_en_o   (csr_rd_en_o),
    .csr_wr_en_o   (csr_wr_en_o),
    .csr_addr_o    (csr_addr_o),
    .csr_wr_data_o (csr_wr_data_o),
    .csr_rd_data_i (csr_rd_data_i),
    .fsm_state_o   (fsm_state_o)
  );

  // ---------------- CSR file model ----------------
  logic [XL-1:0] mem [0:4095];
  logic          mem_loaded = 1'b0;

  assign csr_rd_data_i = mem[csr_addr_o];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem[12'h340] <= 32'h0000_00F0;
      mem[12'h300] <= 32'h0000_1888;
      mem[12'h305] <= 32'h0000_0200;
      mem[12'hF14] <= 32'h0000_0007;
      mem_loaded   <= 1'b1;
    end else if (resetb_i && clk_en_i && csr_wr_en_o) begin
      mem[csr_addr_o] <= csr_wr_data_o;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;

  function automatic logic [W-1:0] ev(input logic [2:0] k, input logic f,
                                       input logic [3:0] lat, input logic [11:0] a,
                                       input logic [31:0] d);
    return {k, f, lat, a, d};
  endfunction

  function automatic string ev_name(input logic [2:0] k);
    case (k)
      EV_ACK:  return "ins_ack";
      EV_RD:   return "csr_read";
      EV_WR:   return "csr_write";
      EV_DONE: return "ins_done";
      EV_TACK: return "trap_ack";
      default: return "unknown";
    endcase
  endfunction

  task automatic check_ev(input logic [W-1:0] obs);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got flag=%0d lat=%0d addr=%h data=%h, expected no event",
               ev_name(obs[51:49]), obs[48], obs[47:44], obs[43:32], obs[31:0]);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got kind=%0d flag=%0d lat=%0d addr=%h data=%h, expected kind=%0d flag=%0d lat=%0d addr=%h data=%h",
                 ev_name(e[51:49]), obs[51:49], obs[48], obs[47:44], obs[43:32], obs[31:0],
                 e[51:49], e[48], e[47:44], e[43:32], e[31:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: one sample per enabled cycle, taken away from the rising edge
  always @(negedge clk) begin
    if (resetb_i && clk_en_i) begin
      cyc++;
      if (ins_ack_o) begin
        ack_cyc = cyc;
        check_ev(ev(EV_ACK, 1'b0, 4'd0, 12'h0, 32'h0));
      end
      if (ins_done_o)
        check_ev(ev(EV_DONE, ins_illegal_o, 4'(cyc - ack_cyc), 12'h0, ins_rd_data_o));
      if (trap_ack_o)
        check_ev(ev(EV_TACK, 1'b0, 4'd0, 12'h0, trap_vec_o));
      if (csr_rd_en_o)
        check_ev(ev(EV_RD, 1'b0, 4'd0, csr_addr_o, 32'h0));
      if (csr_wr_en_o)
        check_ev(ev(EV_WR, 1'b0, 4'd0, csr_addr_o, csr_wr_data_o));
      checks++;
      if ((csr_rd_en_o && csr_wr_en_o) || (fsm_state_o == 3'd0 && (csr_rd_en_o || csr_wr_en_o))) begin
        errors++;
        $display("FAIL strobe_rule: got rd=%0d wr=%0d state=%0d, expected exclusive strobes and none in IDLE",
                 csr_rd_en_o, csr_wr_en_o, fsm_state_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_ins(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic rd_nz, input logic src_nz);
    bit got = 0;
    @(posedge clk); #1;
    ins_req_i    = 1'b1;
    ins_op_i     = op;
    ins_addr_i   = addr;
    ins_src_i    = src;
    ins_rd_nz_i  = rd_nz;
    ins_src_nz_i = src_nz;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ins_ack_o && clk_en_i) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL ins_ack_timeout: got no ins_ack_o in 50 cycles, expected an accept");
    end
    @(posedge clk); #1;
    ins_req_i = 1'b0;
  endtask

  task automatic issue_trap(input logic [31:0] pc, input logic [31:0] cause);
    bit got = 0;
    @(posedge clk); #1;
    trap_req_i   = 1'b1;
    trap_pc_i    = pc;
    trap_cause_i = cause;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (trap_ack_o && clk_en_i) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL trap_ack_timeout: got no trap_ack_o in 50 cycles, expected trap completion");
    end
    @(posedge clk); #1;
    trap_req_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"},     {31'd0, ins_ack_o},     32'd0);
    check_val({tag, "_done"},    {31'd0, ins_done_o},    32'd0);
    check_val({tag, "_illegal"}, {31'd0, ins_illegal_o}, 32'd0);
    check_val({tag, "_rd_data"}, ins_rd_data_o,          32'd0);
    check_val({tag, "_trap_ack"},{31'd0, trap_ack_o},    32'd0);
    check_val({tag, "_trap_vec"},trap_vec_o,             32'd0);
    check_val({tag, "_rd_en"},   {31'd0, csr_rd_en_o},   32'd0);
    check_val({tag, "_wr_en"},   {31'd0, csr_wr_en_o},   32'd0);
    check_val({tag, "_addr"},    {20'd0, csr_addr_o},    32'd0);
    check_val({tag, "_wr_data"}, csr_wr_data_o,          32'd0);
    check_val({tag, "_state"},   {29'd0, fsm_state_o},   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetb_i     = 1'b0;
    clk_en_i     = 1'b1;
    ins_req_i    = 1'b0;
    ins_op_i     = 2'b00;
    ins_addr_i   = 12'h0;
    ins_src_i    = '0;
    ins_rd_nz_i  = 1'b0;
    ins_src_nz_i = 1'b0;
    trap_req_i   = 1'b0;
    trap_pc_i    = '0;
    trap_cause_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetb_i = 1'b1;
    repeat (2) @(posedge clk);

    // CSRRS 0x340: old F0 | 0F -> FF, done 3 cycles after accept
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h340, 32'h0));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h340, 32'h0000_00FF));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd3, 12'h000, 32'h0000_00F0));
    issue_ins(2'b10, 12'h340, 32'h0000_000F, 1'b1, 1'b1);
    wait_drain();

    // CSRRC 0x300 with zero operand: read only, done 2 cycles after accept
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h300, 32'h0));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd2, 12'h000, 32'h0000_1888));
    issue_ins(2'b11, 12'h300, 32'h0, 1'b1, 1'b0);
    wait_drain();

    // CSRRW to read-only 0xF14: illegal, no write
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'hF14, 32'h0));
    exp_q.push_back(ev(EV_DONE, 1'b1, 4'd2, 12'h000, 32'h0000_0007));
    issue_ins(2'b01, 12'hF14, 32'h0000_0005, 1'b1, 1'b1);
    wait_drain();

    // CSRRS 0xF14 with zero operand: pure read of read-only space is legal
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'hF14, 32'h0));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd2, 12'h000, 32'h0000_0007));
    issue_ins(2'b10, 12'hF14, 32'h0, 1'b1, 1'b0);
    wait_drain();

    // op 00 behaves as RW; rd=x0 so no read strobe, old value still captured
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h300, 32'h0000_ABCD));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd3, 12'h000, 32'h0000_1888));
    issue_ins(2'b00, 12'h300, 32'h0000_ABCD, 1'b0, 1'b1);
    wait_drain();

    // CSRRC 0x340 rd=x0: RC always reads; FF & ~0F -> F0
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h340, 32'h0));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h340, 32'h0000_00F0));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd3, 12'h000, 32'h0000_00FF));
    issue_ins(2'b11, 12'h340, 32'h0000_000F, 1'b0, 1'b1);
    wait_drain();

    // trap and instruction together: trap first, then CSRRS 0x340 F0|100
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h341, 32'h0000_0100));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h342, 32'h0000_000B));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h305, 32'h0));
    exp_q.push_back(ev(EV_TACK, 1'b0, 4'd0, 12'h000, 32'h0000_0200));
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h340, 32'h0));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h340, 32'h0000_01F0));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd3, 12'h000, 32'h0000_00F0));
    fork
      issue_trap(32'h0000_0100, 32'h0000_000B);
      issue_ins(2'b10, 12'h340, 32'h0000_0100, 1'b0, 1'b1);
    join
    wait_drain();
    check_val("trap_vec_held", trap_vec_o, 32'h0000_0200);

    // reset during INS_RD: sequence abandoned, no write afterwards
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_RD,   1'b0, 4'd0, 12'h340, 32'h0));
    issue_ins(2'b01, 12'h340, 32'h0000_0055, 1'b1, 1'b1);
    @(negedge clk); #1;
    resetb_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    resetb_i = 1'b1;
    repeat (10) @(posedge clk);
    wait_drain();
    check_val("mem_340_after_reset", mem[12'h340], 32'h0000_01F0);

    // clk_en low for 3 edges in INS_WR: held strobe, single write and done
    exp_q.push_back(ev(EV_ACK,  1'b0, 4'd0, 12'h000, 32'h0));
    exp_q.push_back(ev(EV_WR,   1'b0, 4'd0, 12'h340, 32'h0000_1234));
    exp_q.push_back(ev(EV_DONE, 1'b0, 4'd3, 12'h000, 32'h0000_01F0));
    issue_ins(2'b01, 12'h340, 32'h0000_1234, 1'b0, 1'b1);
    @(posedge clk); #1;
    clk_en_i = 1'b0;
    check_val("stall_state_in", {29'd0, fsm_state_o}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check_val("stall_state_held", {29'd0, fsm_state_o}, 32'd2);
    check_val("stall_wr_en_held", {31'd0, csr_wr_en_o}, 32'd1);
    clk_en_i = 1'b1;
    wait_drain();
    check_val("mem_340_after_stall", mem[12'h340], 32'h0000_1234);

    repeat (5) @(posedge clk);
    check_val("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
